// File: rtl/booth_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_sequencer
// Brief    : Operand handshake and strobe sequencer for an iterative multiplier
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_sequencer #(
    parameter int WIDTH      = 16,
    parameter int RUN_CYCLES = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    output logic                 mult_ld,
    output logic                 mult_ld_pp,
    input  logic [2*WIDTH-1:0]   mult_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    localparam int              CNT_W    = $clog2(RUN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GAP  = 3'd2,
        S_LDPP = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     mult_a_q;
    logic [WIDTH-1:0]     mult_b_q;
    logic                 mult_ld_q;
    logic                 mult_ld_pp_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [2*WIDTH-1:0]   result_q;
    logic [15:0]          ops_done_q;

    logic w_in_hs;
    logic w_out_hs;

    assign w_in_hs  = in_valid & in_ready_q;
    assign w_out_hs = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_ld_q    <= 1'b0;
            mult_ld_pp_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            ops_done_q   <= '0;
        end else begin
            // Strobes are single-cycle pulses; only a transition re-arms them.
            mult_ld_q    <= 1'b0;
            mult_ld_pp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_in_hs) begin
                        state_q    <= S_LOAD;
                        mult_a_q   <= in_a;
                        mult_b_q   <= in_b;
                        mult_ld_q  <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    state_q      <= S_LDPP;
                    mult_ld_pp_q <= 1'b1;
                end
                S_LDPP: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= S_DONE;
                        result_q    <= mult_product;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // in_ready rises only after the output handshake edge.
                    if (w_out_hs) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        ops_done_q  <= ops_done_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_ld    = mult_ld_q;
    assign mult_ld_pp = mult_ld_pp_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign ops_done   = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_sequencer
// Brief    : Scoreboard bench for booth_mult_sequencer with a behavioural multiplier
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_sequencer;

    localparam int WIDTH      = 16;
    localparam int RUN_CYCLES = 18;
    localparam int PW         = 2 * WIDTH;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [WIDTH-1:0]  mult_a;
    logic [WIDTH-1:0]  mult_b;
    logic              mult_ld;
    logic              mult_ld_pp;
    logic [PW-1:0]     mult_product;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     result;
    logic              busy;
    logic [15:0]       ops_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_ops  = 0;
    logic [PW-1:0] sb[$];

    booth_mult_sequencer #(
        .WIDTH      (WIDTH),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_ld      (mult_ld),
        .mult_ld_pp   (mult_ld_pp),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .busy         (busy),
        .ops_done     (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: latches operands on mult_ld, forms the product on mult_ld_pp.
    logic [WIDTH-1:0] m_a_r, m_b_r;
    logic [PW-1:0]    m_prod;
    always @(posedge clk) begin
        if (reset) begin
            m_a_r  <= '0;
            m_b_r  <= '0;
            m_prod <= '0;
        end else begin
            if (mult_ld) begin
                m_a_r  <= mult_a;
                m_b_r  <= mult_b;
                m_prod <= '0;
            end
            if (mult_ld_pp)
                m_prod <= PW'(m_a_r) * PW'(m_b_r);
        end
    end
    assign mult_product = m_prod;

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(posedge clk) begin
        logic [PW-1:0] exp_v;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: result=%h with no pending operation", result);
                end else begin
                    exp_v = sb.pop_front();
                    if (result !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_result: got %h expected %h", result, exp_v);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(PW'(in_a) * PW'(in_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) break;
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL offer_timeout: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (out_valid) break;
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_timeout: out_valid=%b expected 1", out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({in_ready, busy, out_valid, mult_ld, mult_ld_pp} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {rdy,busy,ov,ld,ldpp}=%b expected 10000",
                     {in_ready, busy, out_valid, mult_ld, mult_ld_pp});
        end
        n_checks++;
        if ({mult_a, mult_b, result, ops_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: a=%h b=%h result=%h ops=%h expected all 0",
                     mult_a, mult_b, result, ops_done);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_ov;
        out_ready = 1'b1;
        offer(16'd11, 16'd13);
        // Counter is 0 after handshake+3 edges, so 7 after handshake+10.
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, out_valid, in_ready} !== 3'b001 || ops_done !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b ov=%b rdy=%b ops=%0d expected 0 0 1 0",
                     busy, out_valid, in_ready, ops_done);
        end
        seen_ov = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid || mult_ld || mult_ld_pp) seen_ov = 1'b1;
        end
        n_checks++;
        if (seen_ov !== 1'b0 || ops_done !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_discard: activity=%b ops=%0d expected 0 0", seen_ov, ops_done);
        end
        exp_ops = 0;
    endtask

    task automatic test_basic();
        bit bad;
        out_ready = 1'b1;
        offer(16'd3, 16'd5);
        n_checks++;
        if ({mult_ld, mult_ld_pp, busy, in_ready} !== 4'b1010 || mult_a !== 16'd3 || mult_b !== 16'd5) begin
            n_fail++;
            $display("FAIL basic_load: ld=%b ldpp=%b busy=%b rdy=%b a=%0d b=%0d expected 1 0 1 0 3 5",
                     mult_ld, mult_ld_pp, busy, in_ready, mult_a, mult_b);
        end
        tick();
        n_checks++;
        if ({mult_ld, mult_ld_pp} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_gap: ld=%b ldpp=%b expected 0 0", mult_ld, mult_ld_pp);
        end
        tick();
        n_checks++;
        if ({mult_ld, mult_ld_pp} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_ldpp: ld=%b ldpp=%b expected 0 1", mult_ld, mult_ld_pp);
        end
        bad = 1'b0;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (out_valid || mult_ld || mult_ld_pp || in_ready) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_run_quiet: activity=%b expected 0", bad);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd15) begin
            n_fail++;
            $display("FAIL basic_latency: ov=%b result=%0d expected 1 15", out_valid, result);
        end
        tick();
        exp_ops++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ops_done !== 16'(exp_ops)) begin
            n_fail++;
            $display("FAIL basic_done: ov=%b rdy=%b ops=%0d expected 0 1 %0d",
                     out_valid, in_ready, ops_done, exp_ops);
        end
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        offer(16'hFFFF, 16'hFFFF);
        wait_out(40);
        n_checks++;
        if (result !== 32'hFFFE0001) begin
            n_fail++;
            $display("FAIL max_result: got %h expected fffe0001", result);
        end
        tick();
        exp_ops++;
        n_checks++;
        if (ops_done !== 16'(exp_ops)) begin
            n_fail++;
            $display("FAIL max_ops: got %0d expected %0d", ops_done, exp_ops);
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        out_ready = 1'b0;
        offer(16'd7, 16'd9);
        wait_out(40);
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h0055;
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(out_valid === 1'b1 && result === 32'd63 && in_ready === 1'b0 &&
                  mult_a === 16'd7 && mult_b === 16'd9))
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: ov=%b result=%0d rdy=%b a=%0d expected 1 63 0 7",
                     out_valid, result, in_ready, mult_a);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_ops++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || mult_a !== 16'd7 ||
            ops_done !== 16'(exp_ops)) begin
            n_fail++;
            $display("FAIL bp_release: ov=%b rdy=%b busy=%b a=%0d ops=%0d expected 0 1 0 7 %0d",
                     out_valid, in_ready, busy, mult_a, ops_done, exp_ops);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a_t [3];
        logic [WIDTH-1:0] b_t [3];
        int  hs_cyc [3];
        int  idx, outs, overlap;
        bit  hs, ohs;
        a_t = '{16'd100, 16'd1234, 16'd65535};
        b_t = '{16'd200, 16'd4321, 16'd2};
        hs_cyc = '{0, 0, 0};
        idx = 0; outs = 0; overlap = 0;
        out_ready = 1'b1;
        in_a = a_t[0];
        in_b = b_t[0];
        in_valid = 1'b1;
        for (int c = 0; c < 120 && (idx < 3 || busy); c++) begin
            if (in_ready && out_valid) overlap++;
            hs  = in_valid && in_ready;
            ohs = out_valid && out_ready;
            tick();
            if (ohs) outs++;
            if (hs) begin
                hs_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    in_a = a_t[idx];
                    in_b = b_t[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        exp_ops += outs;
        n_checks++;
        if (idx != 3 || outs != 3) begin
            n_fail++;
            $display("FAIL b2b_count: in_hs=%0d out_hs=%0d expected 3 3", idx, outs);
        end
        n_checks++;
        if (hs_cyc[1] - hs_cyc[0] != 23 || hs_cyc[2] - hs_cyc[1] != 23) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d %0d expected 23 23",
                     hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL b2b_overlap: got %0d cycles expected 0", overlap);
        end
        n_checks++;
        if (ops_done !== 16'(exp_ops)) begin
            n_fail++;
            $display("FAIL b2b_ops: got %0d expected %0d", ops_done, exp_ops);
        end
    endtask

    task automatic test_wrap();
        force dut.ops_done_q = 16'hFFFF;
        tick();
        release dut.ops_done_q;
        tick();
        n_checks++;
        if (ops_done !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h expected ffff", ops_done);
        end
        out_ready = 1'b1;
        offer(16'd5, 16'd6);
        wait_out(40);
        tick();
        n_checks++;
        if (ops_done !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: got %h expected 0000", ops_done);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_basic();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        repeat (2) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d results outstanding expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
